// File: rtl/acq_seq_gen_if.sv
// acq_seq_gen_if: start/abort request, configuration words and status outputs
// of the acquisition-sequence generator, grouped into one bundle.
// Ports: master = host/config side (drives start, abort, cfg), slave = generator.
// Latency: n/a (wires only). Backpressure: none, start is a plain request pulse.
interface acq_seq_gen_if #(
  parameter int CW = 16
);
  logic          start;
  logic          abort;
  logic [CW-1:0] x_points;
  logic [CW-1:0] x_skip;
  logic [CW-1:0] y_lines;
  logic [CW-1:0] cycles_per_point;
  logic [CW-1:0] delay_points;
  logic [CW-1:0] flyback_cycles;
  logic          acq;
  logic          point_strobe;
  logic          line_start;
  logic [CW-1:0] x_idx;
  logic [CW-1:0] y_idx;
  logic          busy;
  logic          done;
  logic          cfg_err;

  modport master (
    output start, abort, x_points, x_skip, y_lines, cycles_per_point,
           delay_points, flyback_cycles,
    input  acq, point_strobe, line_start, x_idx, y_idx, busy, done, cfg_err
  );

  modport slave (
    input  start, abort, x_points, x_skip, y_lines, cycles_per_point,
           delay_points, flyback_cycles,
    output acq, point_strobe, line_start, x_idx, y_idx, busy, done, cfg_err
  );
endinterface

// File: rtl/acq_seq_gen.sv
// acq_seq_gen: raster acquisition-sequence generator (delay, y_lines x x_points, per-point gate/strobes).
// Latency: busy one cycle after start; first SCAN cycle at start+1+delay_points*cycles_per_point.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next edge.
// Ports: clk, rst (sync, active-high), bus (acq_seq_gen_if.slave: start/abort, cfg words, status).
// Optional feature: define ACQ_SEQ_GEN_FLYBACK_EN to insert flyback_cycles idle clocks between lines.
module acq_seq_gen #(
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  acq_seq_gen_if.slave bus
);

  localparam int DW = 2 * CW;

`ifdef ACQ_SEQ_GEN_FLYBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_SCAN, S_FLYBACK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_SCAN, S_DONE} state_t;
`endif

  state_t state, state_nxt;

  // configuration captured at an accepted start
  logic [CW-1:0] xp_q, xs_q, yl_q, cpp_q;
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
  logic [CW-1:0] fb_q;
  logic [CW-1:0] fcnt;
`else
  logic unused_fb;
  assign unused_fb = ^bus.flyback_cycles;
`endif

  logic [DW-1:0] dcnt;
  logic [CW-1:0] pc, x_idx, y_idx;
  logic          cfg_err_q;

  logic [DW-1:0] d_in;
  logic          cfg_ok, start_acc, start_rej, abort_act;
  logic          pt_last, line_last, seq_last;
  logic          acq_w;

  // full-width product so a large delay never truncates
  assign d_in      = DW'(bus.delay_points) * DW'(bus.cycles_per_point);
  assign cfg_ok    = (bus.x_points != '0) && (bus.y_lines != '0) && (bus.cycles_per_point != '0);
  // abort beats a simultaneous start in IDLE
  assign start_acc = (state == S_IDLE) && bus.start && !bus.abort && cfg_ok;
  assign start_rej = (state == S_IDLE) && bus.start && !bus.abort && !cfg_ok;
  assign abort_act = (state != S_IDLE) && bus.abort;

  assign pt_last   = (pc == cpp_q - CW'(1));
  assign line_last = pt_last && (x_idx == xp_q - CW'(1));
  assign seq_last  = line_last && (y_idx == yl_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_act) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start_acc) state_nxt = (d_in != '0) ? S_DELAY : S_SCAN;
        S_DELAY: if (dcnt == '0) state_nxt = S_SCAN;
        S_SCAN: begin
          if (seq_last) begin
            state_nxt = S_DONE;
          end else if (line_last) begin
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
            if (fb_q != '0) state_nxt = S_FLYBACK;
`endif
          end
        end
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
        S_FLYBACK: if (fcnt == '0) state_nxt = S_SCAN;
`endif
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xp_q      <= '0;
      xs_q      <= '0;
      yl_q      <= '0;
      cpp_q     <= '0;
      dcnt      <= '0;
      pc        <= '0;
      x_idx     <= '0;
      y_idx     <= '0;
      cfg_err_q <= 1'b0;
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
      fb_q      <= '0;
      fcnt      <= '0;
`endif
    end else begin
      cfg_err_q <= start_rej;
      if (abort_act || state == S_DONE) begin
        pc    <= '0;
        x_idx <= '0;
        y_idx <= '0;
      end else if (start_acc) begin
        xp_q  <= bus.x_points;
        xs_q  <= bus.x_skip;
        yl_q  <= bus.y_lines;
        cpp_q <= bus.cycles_per_point;
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
        fb_q  <= bus.flyback_cycles;
`endif
        // DELAY exits when dcnt hits 0, so load D-1 for exactly D cycles
        dcnt  <= d_in - DW'(1);
        pc    <= '0;
        x_idx <= '0;
        y_idx <= '0;
      end else begin
        case (state)
          S_DELAY: dcnt <= dcnt - DW'(1);
          S_SCAN: begin
            if (pt_last) begin
              pc <= '0;
              if (line_last) begin
                x_idx <= '0;
                // indices advance before the gap so FLYBACK already shows the next line
                if (!seq_last) y_idx <= y_idx + CW'(1);
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
                fcnt <= fb_q - CW'(1);
`endif
              end else begin
                x_idx <= x_idx + CW'(1);
              end
            end else begin
              pc <= pc + CW'(1);
            end
          end
`ifdef ACQ_SEQ_GEN_FLYBACK_EN
          S_FLYBACK: fcnt <= fcnt - CW'(1);
`endif
          default: ;
        endcase
      end
    end
  end

  // all status outputs decode registered state only
  assign acq_w            = (state == S_SCAN) && (x_idx >= xs_q);
  assign bus.acq          = acq_w;
  assign bus.point_strobe = acq_w && (pc == '0);
  assign bus.line_start   = (state == S_SCAN) && (pc == '0) && (x_idx == '0);
  assign bus.x_idx        = x_idx;
  assign bus.y_idx        = y_idx;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = (state == S_DONE);
  assign bus.cfg_err      = cfg_err_q;

endmodule

// File: doc/acq_seq_gen.md
# acq_seq_gen

Parametrised acquisition-sequence generator for the OCT slave driver. It produces the per-point `acq` gate and sync strobes for a raster scan: an initial delay, then `y_lines` lines of `x_points` points, each point lasting `cycles_per_point` clocks. A leading blanking region suppresses `acq` on the first points of each line, and an optional fly-back gap separates lines. It sits between the host configuration registers and the digitiser trigger logic, and supersedes the fixed 16-bit, free-running generator with a start/abort/done handshake.

## Interface
Parameters:
- `CW`, 16: width of every configuration input and of the `x_idx`/`y_idx` outputs.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  sequence request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; has priority over everything except `rst`.
- `x_points`  in  CW  points per line.
- `x_skip`  in  CW  leading points per line with `acq` held low.
- `y_lines`  in  CW  lines per sequence.
- `cycles_per_point`  in  CW  clocks per point.
- `delay_points`  in  CW  pre-scan delay, in points.
- `flyback_cycles`  in  CW  inter-line gap in clocks; used only with the macro.
- `acq`  out  1  acquisition gate.
- `point_strobe`  out  1  one-cycle pulse at the first cycle of each acquired point.
- `line_start`  out  1  one-cycle pulse at the first cycle of each line.
- `x_idx`  out  CW  current point index.
- `y_idx`  out  CW  current line index.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, DELAY, SCAN, FLYBACK (macro only), DONE.
- On `start` in IDLE, all configuration inputs are latched. Later changes to them have no effect until the next start.
- If `x_points`, `y_lines` or `cycles_per_point` is 0 at `start`, the start is rejected: `cfg_err` pulses and the block stays in IDLE.
- Delay length D = `delay_points` × `cycles_per_point`, computed at 2·CW bits with no truncation.
  - D > 0: IDLE → DELAY for exactly D cycles, then SCAN.
  - D = 0: IDLE → SCAN directly.
- SCAN counters:
  - Point-cycle counter `pc` runs 0..`cycles_per_point`-1. Each point is exactly `cycles_per_point` clocks.
  - `x_idx` runs 0..`x_points`-1; `y_idx` runs 0..`y_lines`-1.
- `acq` = (state == SCAN) && (`x_idx` ≥ `x_skip`). It is decoded from registered state only, with no extra latency. If `x_skip` ≥ `x_points`, `acq` never asserts.
- `point_strobe` = `acq` && `pc` == 0.
- `line_start` = SCAN && `pc` == 0 && `x_idx` == 0.
- At the last cycle of the last point of a line:
  - If `y_idx` < `y_lines`-1: increment `y_idx`, clear `x_idx`, then enter FLYBACK when enabled with `flyback_cycles` > 0, otherwise continue in SCAN on the next cycle.
  - Otherwise: enter DONE.
- DONE lasts one cycle with `done` = 1 and `busy` = 1, then returns to IDLE.
- `start` while `busy` is ignored (no `cfg_err`).
- `abort` in any non-IDLE state returns to IDLE on the next cycle. `acq`, `busy` and strobes go low; `done` does not pulse. `abort` in IDLE is ignored, and wins over a simultaneous `start`.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- `start` sampled at edge k:
  - `busy` = 1 from cycle k+1.
  - First SCAN cycle is k+1+D.
- Total busy cycles = D + `y_lines`·`x_points`·`cycles_per_point` + (`y_lines`-1)·F + 1, where F is the fly-back length (0 without the macro).
- `rst` asserted mid-sequence: at the next edge, reset values are restored and no `done` pulse is produced.
- Counter comparisons use latched values. No wrap-around occurs within legal configurations.

## Configuration
- Macro `ACQ_SEQ_GEN_FLYBACK_EN`.
- Defined: FLYBACK state exists. The block spends `flyback_cycles` cycles in FLYBACK between lines, with `acq` = 0, `busy` = 1 and indices already advanced.
- Undefined: no FLYBACK state. The `flyback_cycles` port is present but ignored, and lines are back-to-back.

## Test plan
- CW=16, x_points=4, x_skip=1, y_lines=2, cycles_per_point=3, delay_points=2; start at cycle 0:
  - `busy` high in cycles 1–31.
  - SCAN in cycles 7–30.
  - `acq` high in cycles 10–18 and 22–30.
  - 6 `point_strobe` pulses; `line_start` at cycles 7 and 19.
  - `done` at cycle 31.
- start with y_lines=0 -> `cfg_err` pulse, `busy` stays 0, no `acq`.
- Same configuration as the first case, `abort` at cycle 12 -> cycle 13 in IDLE, `acq`=`busy`=0, no `done`. A start at cycle 20 then runs a full sequence.
- Macro defined, flyback_cycles=5, first-case configuration -> line 1 SCAN starts at cycle 24 and `done` occurs at cycle 36. Macro undefined, same stimulus -> `done` at cycle 31.
- `start` pulses while busy and config changes mid-run -> no effect on the timing of the first case.
- `rst` at cycle 15 -> all outputs 0 at cycle 16.
- CW=24, cycles_per_point=1, x_skip=x_points=8 -> `acq` never asserts, `done` still pulses.
